// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter.
// FSM state encoding and requester port indices.
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int unsigned PORT0 = 0;
   localparam int unsigned PORT1 = 1;

   // last_grant reset value: port 1, so port 0 wins the first tie
   localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Two-way winner picker, combinational, one-hot grant.
// RAM_ARB_FIXED_PRIO_EN: port 0 always wins ties; else round-robin.
module rr_picker
   import ram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      gnt = 2'b00;
      unique case (1'b1)
         req[PORT0]: gnt[PORT0] = 1'b1;
         req[PORT1]: gnt[PORT1] = 1'b1;
         default:    gnt = 2'b00;
      endcase
   end
`else
   always_comb begin
      gnt = 2'b00;
      unique case (1'b1)
         (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
         (req == 2'b01): gnt = 2'b01;
         (req == 2'b10): gnt = 2'b10;
         default:        gnt = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM.
// Tie-break mode selected by RAM_ARB_FIXED_PRIO_EN (see rr_picker).
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
)(
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_gnt,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_gnt,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy
);

   state_t                state_q, state_d;
   logic                  win_q, win_d;
   logic                  last_q, last_d;
   logic [1:0]            pick;
   logic [1:0]            gnt_d;
   logic [1:0]            rvalid_d;
   logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;
   logic                  en_d, we_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0] wdata_d;

   rr_picker u_picker (
      .req        ({p1_req, p0_req}),
      .last_grant (last_q),
      .gnt        (pick)
   );

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      last_d   = last_q;
      gnt_d    = 2'b00;
      rvalid_d = 2'b00;
      rdata0_d = p0_rdata;
      rdata1_d = p1_rdata;
      en_d     = 1'b0;
      we_d     = 1'b0;
      addr_d   = ram_addr;
      wdata_d  = ram_wdata;
      unique case (state_q)
         IDLE: begin
            if (|pick) begin
               win_d   = pick[PORT1];
               last_d  = pick[PORT1];
               gnt_d   = pick;
               en_d    = 1'b1;
               we_d    = pick[PORT1] ? p1_we    : p0_we;
               addr_d  = pick[PORT1] ? p1_addr  : p0_addr;
               wdata_d = pick[PORT1] ? p1_wdata : p0_wdata;
               state_d = ACCESS;
            end
         end
         // ram_we is high here exactly when the access is a write
         ACCESS: state_d = ram_we ? IDLE : RESP;
         RESP: begin
            rvalid_d[win_q] = 1'b1;
            if (win_q) rdata1_d = ram_rdata;
            else       rdata0_d = ram_rdata;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         win_q     <= 1'b0;
         last_q    <= LAST_GRANT_RST;
         p0_gnt    <= 1'b0;
         p1_gnt    <= 1'b0;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         last_q    <= last_d;
         p0_gnt    <= gnt_d[PORT0];
         p1_gnt    <= gnt_d[PORT1];
         p0_rvalid <= rvalid_d[PORT0];
         p1_rvalid <= rvalid_d[PORT1];
         p0_rdata  <= rdata0_d;
         p1_rdata  <= rdata1_d;
         ram_en    <= en_d;
         ram_we    <= we_d;
         ram_addr  <= addr_d;
         ram_wdata <= wdata_d;
         busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus
// randomized mixed traffic against a transaction-level RAM model.
module tb_ram_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int OW = 7 + 3 * DW + AW;

   logic          clk = 1'b0;
   logic          arst;
   logic          p0_req, p0_we, p0_gnt, p0_rvalid;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata, p0_rdata;
   logic          p1_req, p1_we, p1_gnt, p1_rvalid;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata, p1_rdata;
   logic          ram_en, ram_we, busy;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic [OW-1:0] all_out;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] ram_mem [0:255];
   logic [DW-1:0] ref_mem [0:255];

   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .arst      (arst),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .busy      (busy)
   );

   assign all_out = {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid,
                     p0_rdata, p1_rdata, ram_en, ram_we,
                     ram_addr, ram_wdata, busy};

   // synchronous RAM: read data valid the cycle after ram_en
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram_mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= ram_mem[ram_addr];
      end
   end

   task automatic clear_inputs();
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      arst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (all_out !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h expected 0", all_out);
      end
      arst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (all_out !== '0) begin
         miscompares++;
         $display("FAIL post_reset_idle: got %h expected 0", all_out);
      end
   endtask

   task automatic test_write_read();
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 8'hA5;
      @(negedge clk);
      vectors++;
      if ({p0_gnt, p1_gnt, ram_en, ram_we, busy} !== 5'b10111) begin
         miscompares++;
         $display("FAIL wr_grant: gnt0/gnt1/en/we/busy=%b expected 10111",
                  {p0_gnt, p1_gnt, ram_en, ram_we, busy});
      end
      vectors++;
      if ({ram_addr, ram_wdata} !== 16'h10A5) begin
         miscompares++;
         $display("FAIL wr_bus: addr/data=%h expected 10a5",
                  {ram_addr, ram_wdata});
      end
      p0_req = 1'b0;
      @(negedge clk);
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h10;
      @(negedge clk);
      vectors++;
      if ({p0_gnt, p1_gnt, ram_en, ram_we} !== 4'b0110) begin
         miscompares++;
         $display("FAIL rd_grant: gnt0/gnt1/en/we=%b expected 0110",
                  {p0_gnt, p1_gnt, ram_en, ram_we});
      end
      p1_req = 1'b0;
      @(negedge clk);
      vectors++;
      if ({p1_rvalid, ram_en} !== 2'b00) begin
         miscompares++;
         $display("FAIL rd_early: rvalid/en=%b expected 00",
                  {p1_rvalid, ram_en});
      end
      @(negedge clk);
      vectors++;
      if ({p0_rvalid, p1_rvalid, p1_rdata} !== {2'b01, 8'hA5}) begin
         miscompares++;
         $display("FAIL rd_resp: rv0/rv1/rdata=%b/%b/%h expected 0/1/a5",
                  p0_rvalid, p1_rvalid, p1_rdata);
      end
      @(negedge clk);
      vectors++;
      if ({p1_rvalid, p1_rdata} !== {1'b0, 8'hA5}) begin
         miscompares++;
         $display("FAIL rd_hold: rv1/rdata=%b/%h expected 0/a5",
                  p1_rvalid, p1_rdata);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h10;
      @(negedge clk);
      vectors++;
      if (p0_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_grant: got %b expected 1", p0_gnt);
      end
      p0_req = 1'b0;
      @(negedge clk);
      arst = 1'b1;
      #1;
      vectors++;
      if (all_out !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got %h expected 0", all_out);
      end
      @(negedge clk);
      arst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if ({p0_rvalid, p1_rvalid, ram_en, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_no_rvalid: rv0/rv1/en/busy=%b expected 0000",
                     {p0_rvalid, p1_rvalid, ram_en, busy});
         end
      end
   endtask

   task automatic test_round_robin();
      int ngr = 0;
      logic exp_port;
      pulse_reset();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'h20;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h21;
      for (int c = 0; c < 40 && ngr < 6; c++) begin
         @(negedge clk);
         if (p0_gnt || p1_gnt) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            exp_port = 1'b0;
`else
            exp_port = ngr[0];
`endif
            vectors++;
            if ({p1_gnt, p0_gnt} !== (exp_port ? 2'b10 : 2'b01)) begin
               miscompares++;
               $display("FAIL rr_order[%0d]: gnt1/gnt0=%b%b expected port %0d",
                        ngr, p1_gnt, p0_gnt, exp_port);
            end
            ngr++;
         end
      end
      clear_inputs();
      vectors++;
      if (ngr != 6) begin
         miscompares++;
         $display("FAIL rr_count: got %0d grants expected 6", ngr);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_held_during_access();
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h40; p0_wdata = 8'h3C;
      @(negedge clk);
      vectors++;
      if (p0_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL held_p0_gnt: got %b expected 1", p0_gnt);
      end
      p0_req = 1'b0;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h40;
      @(negedge clk);
      vectors++;
      if (p1_gnt !== 1'b0) begin
         miscompares++;
         $display("FAIL held_p1_early: got %b expected 0", p1_gnt);
      end
      @(negedge clk);
      vectors++;
      if (p1_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL held_p1_gnt: got %b expected 1", p1_gnt);
      end
      p1_req = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({p1_rvalid, p1_rdata} !== {1'b1, 8'h3C}) begin
         miscompares++;
         $display("FAIL held_p1_rdata: rv/rdata=%b/%h expected 1/3c",
                  p1_rvalid, p1_rdata);
      end
   endtask

   task automatic test_withdrawn();
      @(negedge clk);
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h40;
      @(negedge clk);
      vectors++;
      if (p1_gnt !== 1'b1) begin
         miscompares++;
         $display("FAIL wd_p1_gnt: got %b expected 1", p1_gnt);
      end
      p1_req = 1'b0;
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h33; p0_wdata = 8'h77;
      @(negedge clk);
      p0_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vectors++;
         if ({p0_gnt, ram_en} !== 2'b00) begin
            miscompares++;
            $display("FAIL wd_no_access: gnt0/en=%b expected 00",
                     {p0_gnt, ram_en});
         end
      end
   endtask

   task automatic test_random();
      bit            pend   [2];
      bit            twe    [2];
      logic [AW-1:0] taddr  [2];
      logic [DW-1:0] twd    [2];
      int            rv_due [2];
      logic [DW-1:0] rv_exp [2];
      int            wcnt   [2];
      int            done = 0;
      bit            abort = 0;
      logic          g, rv, exp_rv;
      logic [DW-1:0] rd;
      for (int n = 0; n < 2; n++) begin
         pend[n] = 0; rv_due[n] = -1; wcnt[n] = 0;
      end
      for (int c = 0; c < 20000 && done < 1000 && !abort; c++) begin
         @(negedge clk);
         vectors++;
         if ((p0_gnt && p1_gnt) || (ram_we && !ram_en)) begin
            miscompares++;
            $display("FAIL rnd_exclusive: gnt0/gnt1/en/we=%b expected no overlap",
                     {p0_gnt, p1_gnt, ram_en, ram_we});
         end
         for (int n = 0; n < 2; n++) begin
            g  = n ? p1_gnt : p0_gnt;
            rv = n ? p1_rvalid : p0_rvalid;
            rd = n ? p1_rdata : p0_rdata;
            exp_rv = 1'b0;
            if (rv_due[n] > 0) begin
               rv_due[n]--;
               if (rv_due[n] == 0) begin
                  exp_rv = 1'b1;
                  rv_due[n] = -1;
               end
            end
            vectors++;
            if (rv !== exp_rv) begin
               miscompares++;
               $display("FAIL rnd_rvalid p%0d: got %b expected %b", n, rv, exp_rv);
            end
            if (exp_rv) begin
               vectors++;
               if (rd !== rv_exp[n]) begin
                  miscompares++;
                  $display("FAIL rnd_rdata p%0d: got %h expected %h",
                           n, rd, rv_exp[n]);
               end
               done++;
            end
            if (g) begin
               vectors++;
               if (!pend[n]) begin
                  miscompares++;
                  $display("FAIL rnd_spurious_gnt p%0d: got 1 expected 0", n);
               end else begin
                  pend[n] = 0;
                  if (twe[n]) begin
                     ref_mem[taddr[n]] = twd[n];
                     done++;
                  end else begin
                     rv_exp[n] = ref_mem[taddr[n]];
                     rv_due[n] = 2;
                  end
               end
            end
            if (pend[n]) begin
               wcnt[n]++;
               if (wcnt[n] > 20) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL rnd_timeout p%0d: no grant in 20 cycles", n);
                  abort = 1;
               end
            end else if (rv_due[n] < 0 && $urandom_range(0, 3) != 0) begin
               pend[n]  = 1;
               wcnt[n]  = 0;
               twe[n]   = 1'($urandom_range(0, 1));
               taddr[n] = AW'(8'h80 + $urandom_range(0, 15));
               twd[n]   = DW'($urandom);
            end
         end
         p0_req = pend[0]; p0_we = twe[0]; p0_addr = taddr[0]; p0_wdata = twd[0];
         p1_req = pend[1]; p1_we = twe[1]; p1_addr = taddr[1]; p1_wdata = twd[1];
      end
      clear_inputs();
      vectors++;
      if (done < 1000) begin
         miscompares++;
         $display("FAIL rnd_completed: got %0d expected 1000", done);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = '0;
         ref_mem[i] = '0;
      end
      ram_rdata = '0;
      arst = 1'b0;
      clear_inputs();
      test_reset();
      test_write_read();
      test_reset_mid();
      test_round_robin();
      test_held_during_access();
      test_withdrawn();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
